contador_arbiter: RTL and testbench

CONTADOR_ARBITER -- requirements
Module: contador_arbiter

---
 rtl/contador_arbiter_pkg.sv | 13 +
 rtl/contador_arbiter_counter.sv | 39 +++
 rtl/contador_arbiter.sv | 121 ++++++++++++
 tb/tb_contador_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/contador_arbiter_pkg.sv
// rtl/contador_arbiter_pkg.sv - shared state encoding and parameter defaults
package contador_arbiter_pkg;

   localparam int DEF_NREQ  = 3;
   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/contador_arbiter_counter.sv
// rtl/contador_arbiter_counter.sv - shared counter with clear, enable and terminal compare
module contador_arbiter_counter
   import contador_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] count,
   output logic             at_target
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign at_target = (count_q == target);

endmodule

// File: rtl/contador_arbiter.sv
// rtl/contador_arbiter.sv - round-robin arbiter granting a shared counter to one requester at a time
module contador_arbiter
   import contador_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] len,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic [NREQ-1:0]       done
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e           state_q,  state_d;
   logic [NREQ-1:0]  gnt_q,    gnt_d;
   logic [IDXW-1:0]  winner_q, winner_d;
   logic [IDXW-1:0]  last_q,   last_d;
   logic [WIDTH-1:0] target_q, target_d;

   logic             rr_found;
   logic [IDXW-1:0]  rr_idx;
   logic             cnt_clr;
   logic             cnt_en;
   logic             at_target;

   // Search begins just after the previous winner so every requester gets a turn.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int off = 1; off <= NREQ; off++) begin
         if (!rr_found && req[(int'(last_q) + off) % NREQ]) begin
            rr_found = 1'b1;
            rr_idx   = IDXW'((int'(last_q) + off) % NREQ);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      winner_d = winner_q;
      last_d   = last_q;
      target_d = target_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (rr_found) begin
               state_d  = COUNT;
               winner_d = rr_idx;
               gnt_d    = NREQ'(1) << rr_idx;
               target_d = len[int'(rr_idx)*WIDTH +: WIDTH];
            end
         end
         COUNT: begin
            // A dropped request wins over reaching the terminal count.
            if (!req[winner_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
               last_d  = winner_q;
               cnt_clr = 1'b1;
            end else if (at_target) begin
               state_d = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = winner_q;
            cnt_clr = 1'b1;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         winner_q <= '0;
         last_q   <= IDXW'(NREQ - 1);
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         winner_q <= winner_d;
         last_q   <= last_d;
         target_q <= target_d;
      end
   end

   contador_arbiter_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .target   (target_q),
      .count    (count),
      .at_target(at_target)
   );

   assign gnt  = gnt_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE) ? gnt_q : '0;

endmodule

// File: tb/tb_contador_arbiter.sv
// tb/tb_contador_arbiter.sv - self-checking bench for contador_arbiter
module tb_contador_arbiter;

   localparam int NREQ  = 3;
   localparam int WIDTH = 4;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] len;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      count;
   logic                  busy;
   logic [NREQ-1:0]       done;

   int vectors;
   int miscompares;

   // Reference model: elapsed cycles since grant instead of explicit states.
   bit m_active;
   int m_w;
   int m_len;
   int m_t;
   int m_last;

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [11:0] len;
      logic [2:0]  gnt;
      logic [3:0]  cnt;
      logic        busy;
      logic [2:0]  done;
   } vec_t;

   vec_t tab[$];

   contador_arbiter #(
      .NREQ (NREQ),
      .WIDTH(WIDTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .len  (len),
      .gnt  (gnt),
      .count(count),
      .busy (busy),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [2:0] q, input logic [11:0] l);
      if (r) begin
         m_active = 1'b0;
         m_last   = NREQ - 1;
      end else if (!m_active) begin
         for (int off = 1; off <= NREQ; off++) begin
            int c;
            c = (m_last + off) % NREQ;
            if (!m_active && q[c]) begin
               m_active = 1'b1;
               m_w      = c;
               m_len    = int'((l >> (WIDTH * c)) & 12'hF);
               m_t      = 0;
            end
         end
      end else if (m_t <= m_len) begin
         if (!q[m_w]) begin
            m_active = 1'b0;
            m_last   = m_w;
         end else begin
            m_t = m_t + 1;
         end
      end else begin
         m_active = 1'b0;
         m_last   = m_w;
      end
   endtask

   task automatic cyc(input logic r, input logic [2:0] q, input logic [11:0] l);
      reset = r;
      req   = q;
      len   = l;
      @(posedge clk);
      model_step(r, q, l);
      #1;
   endtask

   task automatic tv(input logic r, input logic [2:0] q, input logic [11:0] l,
                     input logic [2:0] g, input logic [3:0] c, input logic b, input logic [2:0] d);
      vec_t v;
      v.rst = r; v.req = q; v.len = l; v.gnt = g; v.cnt = c; v.busy = b; v.done = d;
      tab.push_back(v);
   endtask

   task automatic check_out(input string tag, input logic [2:0] g, input logic [3:0] c,
                            input logic b, input logic [2:0] d);
      check({tag, " gnt"},   32'(gnt),   32'(g));
      check({tag, " count"}, 32'(count), 32'(c));
      check({tag, " busy"},  32'(busy),  32'(b));
      check({tag, " done"},  32'(done),  32'(d));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_active    = 1'b0;
      m_last      = NREQ - 1;
      m_w = 0; m_len = 0; m_t = 0;
      reset = 1'b1;
      req   = '0;
      len   = '0;

      // single request, len[0]=4
      tv(1'b1, 3'b000, 12'h000, 3'b000, 4'd0, 1'b0, 3'b000);
      tv(1'b0, 3'b001, 12'h004, 3'b001, 4'd0, 1'b1, 3'b000);
      tv(1'b0, 3'b001, 12'h004, 3'b001, 4'd1, 1'b1, 3'b000);
      tv(1'b0, 3'b001, 12'h004, 3'b001, 4'd2, 1'b1, 3'b000);
      tv(1'b0, 3'b001, 12'h004, 3'b001, 4'd3, 1'b1, 3'b000);
      tv(1'b0, 3'b001, 12'h004, 3'b001, 4'd4, 1'b1, 3'b000);
      tv(1'b0, 3'b001, 12'h004, 3'b001, 4'd4, 1'b1, 3'b001);
      tv(1'b0, 3'b000, 12'h004, 3'b000, 4'd0, 1'b0, 3'b000);
      // zero length on requester 1
      tv(1'b0, 3'b010, 12'h000, 3'b010, 4'd0, 1'b1, 3'b000);
      tv(1'b0, 3'b010, 12'h000, 3'b010, 4'd0, 1'b1, 3'b010);
      tv(1'b0, 3'b000, 12'h000, 3'b000, 4'd0, 1'b0, 3'b000);
      // fairness: all requesting, all len=1
      tv(1'b1, 3'b000, 12'h000, 3'b000, 4'd0, 1'b0, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b001, 4'd0, 1'b1, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b001, 4'd1, 1'b1, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b001, 4'd1, 1'b1, 3'b001);
      tv(1'b0, 3'b111, 12'h111, 3'b000, 4'd0, 1'b0, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b010, 4'd0, 1'b1, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b010, 4'd1, 1'b1, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b010, 4'd1, 1'b1, 3'b010);
      tv(1'b0, 3'b111, 12'h111, 3'b000, 4'd0, 1'b0, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b100, 4'd0, 1'b1, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b100, 4'd1, 1'b1, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b100, 4'd1, 1'b1, 3'b100);
      tv(1'b0, 3'b111, 12'h111, 3'b000, 4'd0, 1'b0, 3'b000);
      tv(1'b0, 3'b111, 12'h111, 3'b001, 4'd0, 1'b1, 3'b000);
      tv(1'b0, 3'b000, 12'h111, 3'b000, 4'd0, 1'b0, 3'b000);

      for (int i = 0; i < tab.size(); i++) begin
         cyc(tab[i].rst, tab[i].req, tab[i].len);
         check_out($sformatf("tab%0d", i), tab[i].gnt, tab[i].cnt, tab[i].busy, tab[i].done);
      end

      // abort when count reaches 5, then requester 0 wins next
      cyc(1'b1, 3'b000, 12'h000);
      cyc(1'b0, 3'b100, 12'hF00);
      check_out("abort grant", 3'b100, 4'd0, 1'b1, 3'b000);
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b0, 3'b100, 12'hF00);
         check($sformatf("abort run%0d done", k), 32'(done), 32'(0));
      end
      check("abort count5", 32'(count), 32'(5));
      cyc(1'b0, 3'b000, 12'hF00);
      check_out("abort idle", 3'b000, 4'd0, 1'b0, 3'b000);
      cyc(1'b0, 3'b111, 12'h111);
      check("abort regrant", 32'(gnt), 32'(3'b001));

      // reset asserted when count reaches 7
      cyc(1'b1, 3'b000, 12'h000);
      cyc(1'b0, 3'b001, 12'h00F);
      for (int k = 1; k <= 7; k++) begin
         cyc(1'b0, 3'b001, 12'h00F);
         check($sformatf("rstmid run%0d done", k), 32'(done), 32'(0));
      end
      check("rstmid count7", 32'(count), 32'(7));
      cyc(1'b1, 3'b001, 12'h00F);
      check_out("rstmid reset", 3'b000, 4'd0, 1'b0, 3'b000);
      cyc(1'b0, 3'b101, 12'h00F);
      check("rstmid regrant", 32'(gnt), 32'(3'b001));

      // maximum length with len changed during COUNT
      cyc(1'b1, 3'b000, 12'h000);
      cyc(1'b0, 3'b001, 12'h00F);
      check_out("maxlen grant", 3'b001, 4'd0, 1'b1, 3'b000);
      for (int k = 2; k <= 17; k++) begin
         cyc(1'b0, 3'b001, 12'h002);
         if (k <= 16)
            check_out($sformatf("maxlen c%0d", k), 3'b001, 4'(k - 1), 1'b1, 3'b000);
         else
            check_out("maxlen done", 3'b001, 4'd15, 1'b1, 3'b001);
      end
      cyc(1'b0, 3'b000, 12'h002);
      check_out("maxlen idle", 3'b000, 4'd0, 1'b0, 3'b000);

      // randomized traffic against the reference model
      cyc(1'b1, 3'b000, 12'h000);
      for (int k = 0; k < 400; k++) begin
         logic [2:0]  q;
         logic [11:0] l;
         logic        r;
         q = req;
         if ($urandom_range(3) == 0) q = 3'($urandom_range(7));
         l = 12'($urandom);
         r = ($urandom_range(99) == 0);
         cyc(r, q, l);
         check_out($sformatf("rnd%0d", k),
                   m_active ? 3'(1 << m_w) : 3'b000,
                   m_active ? 4'((m_t < m_len) ? m_t : m_len) : 4'd0,
                   m_active,
                   (m_active && m_t == m_len + 1) ? 3'(1 << m_w) : 3'b000);
         check($sformatf("rnd%0d onehot", k), 32'($countones(gnt) <= 1), 32'(1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
